// File: rtl/drum_init_pkg.sv
// -----------------------------------------------------------------------------
// drum_init_pkg
// Shared definitions for the drum-mesh initialisation path.
//   - mode_t   : profile shape selector (column triangle / pyramid pluck)
//   - state_t  : generator FSM states
//   - DEF_WIDTH / DEF_PEAK : default node-value format shared with the
//     node-update modules (signed fixed point 1.17, apex 0.25)
//   - half_len : H = floor((N-1)/2), the ramp length of one profile axis
// -----------------------------------------------------------------------------
package drum_init_pkg;

    localparam int                   DEF_WIDTH = 18;
    localparam logic [DEF_WIDTH-1:0] DEF_PEAK  = 18'h08000;

    typedef enum logic {
        MODE_TRI_1D  = 1'b0,
        MODE_PYRAMID = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    function automatic int half_len(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/profile_stepper.sv
// -----------------------------------------------------------------------------
// profile_stepper
// Walks p(i) = floor(k(i) * PEAK / H) along one mesh axis without a divider.
// The value advances by the quotient Q = PEAK / H per step while an error
// term accumulates the remainder R = PEAK % H; whenever the error wraps past
// H a unit carry (or borrow) is applied, so the result is exact at every i.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   inc    in   step up one position on the rising ramp
//   dec    in   step down one position on the falling ramp
//   clr    in   return to position 0 (value 0, error 0); wins over inc/dec
//   value  out  current profile value, WIDTH bits
// -----------------------------------------------------------------------------
module profile_stepper #(
    parameter int               WIDTH = 18,
    parameter int               N     = 30,
    parameter logic [WIDTH-1:0] PEAK  = 18'h08000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    localparam int H  = (N - 1) / 2;
    localparam int EW = $clog2(H) + 1;
    localparam int Q  = int'(PEAK) / H;
    localparam int R  = int'(PEAK) % H;

    localparam logic [WIDTH:0]         Q_V   = (WIDTH + 1)'(Q);
    localparam logic [WIDTH:0]         ONE_V = (WIDTH + 1)'(1);
    localparam logic signed [EW:0]     R_E   = (EW + 1)'(R);
    localparam logic signed [EW:0]     H_E   = (EW + 1)'(H);

    // One guard bit above WIDTH so intermediate sums never alias negative.
    logic [WIDTH:0]        r_value;
    logic signed [EW-1:0]  r_err;

    // err +/- R can reach 2H-2 or dip to -(H-1); one extra bit holds both.
    logic signed [EW:0]    w_err_up;
    logic signed [EW:0]    w_err_dn;

    assign w_err_up = $signed({r_err[EW-1], r_err}) + R_E;
    assign w_err_dn = $signed({r_err[EW-1], r_err}) - R_E;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_value <= '0;
            r_err   <= '0;
        end else if (inc) begin
            if (w_err_up >= H_E) begin
                r_err   <= EW'(w_err_up - H_E);
                r_value <= r_value + Q_V + ONE_V;
            end else begin
                r_err   <= EW'(w_err_up);
                r_value <= r_value + Q_V;
            end
        end else if (dec) begin
            if (w_err_dn[EW]) begin
                r_err   <= EW'(w_err_dn + H_E);
                r_value <= r_value - Q_V - ONE_V;
            end else begin
                r_err   <= EW'(w_err_dn);
                r_value <= r_value - Q_V;
            end
        end
    end

    assign value = r_value[WIDTH-1:0];

endmodule

// File: rtl/init_profile_gen.sv
// -----------------------------------------------------------------------------
// init_profile_gen
// Streams the N_ROWS x N_COLS initial displacement of the drum mesh in
// row-major order over a valid/ready handshake. Mode 0 repeats a column
// triangle on every row; mode 1 emits a pyramid min(p(row), p(col)).
// Two profile_stepper instances produce p(row) and p(col) exactly.
//
// Build option:
//   INIT_CHECKSUM_EN  when defined, checksum accumulates the sign-extended
//                     out_data of every handshake (cleared on start, held in
//                     IDLE); when undefined checksum is tied to 0.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a frame (honoured only in IDLE)
//   mode       in   0 = column triangle, 1 = pyramid; latched on start
//   out_valid  out  out_data/out_row/out_col/out_last are valid
//   out_ready  in   consumer accepts the current beat
//   out_data   out  node value, signed 1.17
//   out_row    out  row index of out_data
//   out_col    out  column index of out_data
//   out_last   out  final node (N_ROWS-1, N_COLS-1)
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last handshake
//   checksum   out  running 32-bit sum of emitted values
// -----------------------------------------------------------------------------
module init_profile_gen
    import drum_init_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter int               N_ROWS = 30,
    parameter int               N_COLS = 30,
    parameter logic [WIDTH-1:0] PEAK   = DEF_PEAK
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(N_ROWS)-1:0] out_row,
    output logic [$clog2(N_COLS)-1:0] out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               checksum
);

    localparam int RW    = $clog2(N_ROWS);
    localparam int CW    = $clog2(N_COLS);
    localparam int ROW_H = half_len(N_ROWS);
    localparam int COL_H = half_len(N_COLS);

    // Next-index thresholds: inc while next <= H, dec while next > N-1-H.
    // One extra bit so index+1 never wraps when N is a power of two.
    localparam logic [RW:0]   ROW_INC_MAX = (RW + 1)'(ROW_H);
    localparam logic [RW:0]   ROW_DEC_MIN = (RW + 1)'(N_ROWS - 1 - ROW_H);
    localparam logic [CW:0]   COL_INC_MAX = (CW + 1)'(COL_H);
    localparam logic [CW:0]   COL_DEC_MIN = (CW + 1)'(N_COLS - 1 - COL_H);
    localparam logic [RW-1:0] ROW_LAST    = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(N_COLS - 1);

    state_t        r_state;
    mode_t         r_mode;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic             w_accept;
    logic             w_fire;
    logic             w_col_end;
    logic             w_last;
    logic [RW:0]      w_row_nxt;
    logic [CW:0]      w_col_nxt;
    logic             w_row_inc;
    logic             w_row_dec;
    logic             w_row_clr;
    logic             w_col_inc;
    logic             w_col_dec;
    logic             w_col_clr;
    logic [WIDTH-1:0] w_row_val;
    logic [WIDTH-1:0] w_col_val;
    logic [WIDTH-1:0] w_pyr;
    logic [WIDTH-1:0] w_data;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_fire    = r_valid && out_ready;
    assign w_col_end = (r_col == COL_LAST);
    assign w_last    = w_col_end && (r_row == ROW_LAST);
    assign w_row_nxt = {1'b0, r_row} + (RW + 1)'(1);
    assign w_col_nxt = {1'b0, r_col} + (CW + 1)'(1);

    // Column stepper restarts at every row wrap; the row stepper only moves
    // on a wrap. Both clear on the last beat so DONE/IDLE present zeros.
    assign w_col_clr = w_accept || (w_fire && w_col_end);
    assign w_col_inc = w_fire && !w_col_end && (w_col_nxt <= COL_INC_MAX);
    assign w_col_dec = w_fire && !w_col_end && (w_col_nxt >  COL_DEC_MIN);
    assign w_row_clr = w_accept || (w_fire && w_last);
    assign w_row_inc = w_fire && w_col_end && !w_last && (w_row_nxt <= ROW_INC_MAX);
    assign w_row_dec = w_fire && w_col_end && !w_last && (w_row_nxt >  ROW_DEC_MIN);

    profile_stepper #(
        .WIDTH (WIDTH),
        .N     (N_ROWS),
        .PEAK  (PEAK)
    ) u_row_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_row_inc),
        .dec   (w_row_dec),
        .clr   (w_row_clr),
        .value (w_row_val)
    );

    profile_stepper #(
        .WIDTH (WIDTH),
        .N     (N_COLS),
        .PEAK  (PEAK)
    ) u_col_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_col_inc),
        .dec   (w_col_dec),
        .clr   (w_col_clr),
        .value (w_col_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= MODE_TRI_1D;
            r_row   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= EMIT;
                        r_mode  <= mode_t'(mode);
                        r_row   <= '0;
                        r_col   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_col_end) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_pyr  = (w_row_val < w_col_val) ? w_row_val : w_col_val;
    assign w_data = (r_mode == MODE_PYRAMID) ? w_pyr : w_col_val;

    assign out_valid = r_valid;
    assign out_data  = r_valid ? w_data : '0;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = r_valid && w_last;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef INIT_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_checksum <= '0;
        end else if (w_fire) begin
            r_checksum <= r_checksum + {{(32 - WIDTH){out_data[WIDTH-1]}}, out_data};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_init_profile_gen.sv
module tb_init_profile_gen;

    typedef struct packed {
        logic [17:0] data;
        logic [4:0]  row;
        logic [4:0]  col;
        logic        last;
    } beat_t;

`ifdef INIT_CHECKSUM_EN
    localparam logic [31:0] CKS_EXP = 32'h00E0FE98;
`else
    localparam logic [31:0] CKS_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        a_start = 1'b0, a_mode = 1'b0, a_ready = 1'b1;
    logic        a_valid, a_last, a_busy, a_done;
    logic [17:0] a_data;
    logic [4:0]  a_row, a_col;
    logic [31:0] a_cks;

    logic        b_start = 1'b0, b_mode = 1'b0, b_ready = 1'b1;
    logic        b_valid, b_last, b_busy, b_done;
    logic [17:0] b_data;
    logic [4:0]  b_row, b_col;
    logic [31:0] b_cks;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t q_a[$];
    beat_t q_b[$];
    bit    a_mode_exp = 1'b0;
    int    a_beats = 0, b_beats = 0;
    bit    a_pend_done = 1'b0, b_pend_done = 1'b0;
    bit    a_bp = 1'b0, a_force_low = 1'b0;
    int    a_stall = 0;
    bit    a_stall_prev = 1'b0;
    beat_t a_snap;

    init_profile_gen #(.WIDTH(18), .N_ROWS(30), .N_COLS(30), .PEAK(18'h08000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_row(a_row), .out_col(a_col), .out_last(a_last),
        .busy(a_busy), .done(a_done), .checksum(a_cks)
    );

    init_profile_gen #(.WIDTH(18), .N_ROWS(31), .N_COLS(31), .PEAK(18'h08000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_row(b_row), .out_col(b_col), .out_last(b_last),
        .busy(b_busy), .done(b_done), .checksum(b_cks)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference profile straight from the closed form.
    function automatic logic [17:0] prof(input int i, input int n);
        int h;
        int k;
        h = (n - 1) / 2;
        k = (i < n - 1 - i) ? i : n - 1 - i;
        return 18'((k * 32768) / h);
    endfunction

    // Hand-computed reference points.
    function automatic bit spot(input int n, input bit m, input int r, input int c,
                                output logic [17:0] v);
        spot = 1'b1;
        v    = '0;
        if      (n == 30 && !m && r == 0  && c == 1)  v = 18'h00924;
        else if (n == 30 && !m && r == 0  && c == 3)  v = 18'h01B6D;
        else if (n == 30 && !m && r == 0  && c == 14) v = 18'h08000;
        else if (n == 30 && !m && r == 0  && c == 15) v = 18'h08000;
        else if (n == 30 && !m && r == 0  && c == 29) v = 18'h00000;
        else if (n == 30 && !m && r == 17 && c == 1)  v = 18'h00924;
        else if (n == 30 && !m && r == 17 && c == 15) v = 18'h08000;
        else if (n == 30 &&  m && r == 0  && c == 7)  v = 18'h00000;
        else if (n == 30 &&  m && r == 0  && c == 15) v = 18'h00000;
        else if (n == 30 &&  m && r == 14 && c == 3)  v = 18'h01B6D;
        else if (n == 30 &&  m && r == 7  && c == 20) v = 18'h04000;
        else if (n == 30 &&  m && r == 14 && c == 15) v = 18'h08000;
        else if (n == 31 && !m && r == 0  && c == 1)  v = 18'h00888;
        else if (n == 31 && !m && r == 0  && c == 14) v = 18'h07777;
        else if (n == 31 && !m && r == 0  && c == 15) v = 18'h08000;
        else if (n == 31 && !m && r == 0  && c == 16) v = 18'h07777;
        else if (n == 31 && !m && r == 0  && c == 30) v = 18'h00000;
        else spot = 1'b0;
    endfunction

    task automatic push_frame(input int n, input bit m, input bit to_b);
        beat_t b;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                b.data = m ? ((prof(r, n) < prof(c, n)) ? prof(r, n) : prof(c, n)) : prof(c, n);
                b.row  = 5'(r);
                b.col  = 5'(c);
                b.last = (r == n - 1) && (c == n - 1);
                if (to_b) q_b.push_back(b);
                else      q_a.push_back(b);
            end
        end
    endtask

    // Monitor / scoreboard for the 30x30 instance.
    always @(negedge clk) begin
        beat_t       e;
        logic [17:0] sv;
        if (a_pend_done) begin
            check("a_done_pulse", a_done, 1);
            check("a_valid_in_done", a_valid, 0);
            a_pend_done = 1'b0;
        end else if (a_done === 1'b1) begin
            check("a_done_spurious", a_done, 0);
        end
        if (a_stall_prev && a_valid === 1'b1) begin
            check("a_stall_data", a_data, a_snap.data);
            check("a_stall_row",  a_row,  a_snap.row);
            check("a_stall_col",  a_col,  a_snap.col);
            check("a_stall_last", a_last, a_snap.last);
        end
        a_stall_prev = (a_valid === 1'b1) && (a_ready === 1'b0);
        a_snap       = {a_data, a_row, a_col, a_last};
        if (a_valid === 1'b1 && a_ready === 1'b1) begin
            check("a_busy", a_busy, 1);
            if (q_a.size() == 0) begin
                check("a_unexpected_beat_row", a_row, 32'hFFFF_FFFF);
            end else begin
                e = q_a.pop_front();
                check("a_data", a_data, e.data);
                check("a_row",  a_row,  e.row);
                check("a_col",  a_col,  e.col);
                check("a_last", a_last, e.last);
            end
            if (spot(30, a_mode_exp, int'(a_row), int'(a_col), sv))
                check("a_spot", a_data, sv);
            a_beats++;
            if (a_last) a_pend_done = 1'b1;
        end
    end

    // Monitor / scoreboard for the 31x31 instance.
    always @(negedge clk) begin
        beat_t       e;
        logic [17:0] sv;
        if (b_pend_done) begin
            check("b_done_pulse", b_done, 1);
            b_pend_done = 1'b0;
        end else if (b_done === 1'b1) begin
            check("b_done_spurious", b_done, 0);
        end
        if (b_valid === 1'b1 && b_ready === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_beat_row", b_row, 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                check("b_data", b_data, e.data);
                check("b_row",  b_row,  e.row);
                check("b_col",  b_col,  e.col);
                check("b_last", b_last, e.last);
            end
            if (spot(31, 1'b0, int'(b_row), int'(b_col), sv))
                check("b_spot", b_data, sv);
            b_beats++;
            if (b_last) b_pend_done = 1'b1;
        end
    end

    // Ready driver: always-ready, forced low, or random with 5-cycle stalls.
    initial forever begin
        @(posedge clk);
        #1;
        if (a_force_low)      a_ready = 1'b0;
        else if (!a_bp)       a_ready = 1'b1;
        else if (a_stall > 0) begin
            a_ready = 1'b0;
            a_stall--;
        end else if ($urandom_range(0, 9) == 0) begin
            a_ready = 1'b0;
            a_stall = 4;
        end else begin
            a_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_a(input bit m);
        @(posedge clk);
        #1;
        check("a_idle_valid", a_valid, 0);
        a_start = 1'b1;
        a_mode  = m;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        check("a_latency_valid", a_valid, 1);
    endtask

    task automatic wait_done_a(input int budget);
        int cyc;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (a_done !== 1'b1) check("a_done_timeout", a_done, 1);
    endtask

    // Called in the DONE cycle: a start here must be ignored.
    task automatic finish_frame_a(input bit chk_cks);
        a_start = 1'b1;
        a_mode  = ~a_mode_exp;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        @(negedge clk);
        check("a_valid_after_done", a_valid, 0);
        check("a_busy_after_done",  a_busy,  0);
        check("a_beats", a_beats, 900);
        check("a_queue_left", q_a.size(), 0);
        if (chk_cks) check("a_checksum", a_cks, CKS_EXP);
    endtask

    task automatic run_frame_a(input bit m, input bit bp);
        a_bp       = bp;
        a_beats    = 0;
        a_mode_exp = m;
        push_frame(30, m, 1'b0);
        start_a(m);
        wait_done_a(8000);
        finish_frame_a(!m);
        a_bp = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    a_valid, 0);
        check("rst_data",     a_data,  0);
        check("rst_row",      a_row,   0);
        check("rst_col",      a_col,   0);
        check("rst_last",     a_last,  0);
        check("rst_busy",     a_busy,  0);
        check("rst_done",     a_done,  0);
        check("rst_checksum", a_cks,   0);
        check("rst_b_valid",  b_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame_a(1'b0, 1'b0);
        run_frame_a(1'b1, 1'b0);
        run_frame_a(1'b0, 1'b1);
        run_frame_a(1'b1, 1'b1);

        // 31x31 mesh: odd length, single apex column.
        b_beats = 0;
        push_frame(31, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (b_done !== 1'b1) check("b_done_timeout", b_done, 1);
        @(negedge clk);
        check("b_beats", b_beats, 961);
        check("b_valid_after_done", b_valid, 0);

        // Mid-frame reset at beat 400, then a clean restart.
        a_beats    = 0;
        a_mode_exp = 1'b0;
        push_frame(30, 1'b0, 1'b0);
        start_a(1'b0);
        cyc = 0;
        while (a_beats < 400 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("a_reached_beat_400", (a_beats >= 400), 1);
        #1;
        rst_n       = 1'b0;
        a_force_low = 1'b1;
        a_ready     = 1'b0;
        q_a.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid",    a_valid, 0);
        check("mid_rst_data",     a_data,  0);
        check("mid_rst_row",      a_row,   0);
        check("mid_rst_col",      a_col,   0);
        check("mid_rst_last",     a_last,  0);
        check("mid_rst_busy",     a_busy,  0);
        check("mid_rst_done",     a_done,  0);
        check("mid_rst_checksum", a_cks,   0);
        a_force_low = 1'b0;
        a_beats     = 0;
        push_frame(30, 1'b0, 1'b0);
        start_a(1'b0);
        repeat (50) @(posedge clk);
        #1;
        a_start = 1'b1;
        a_mode  = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_mode  = 1'b0;
        wait_done_a(3000);
        finish_frame_a(1'b1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/init_profile_gen.md
Name: init_profile_gen

Overview:
- Sequential generator for drum-mesh initial displacement.
- Streams N_ROWS x N_COLS node values in row-major order over a valid/ready handshake, replacing fixed 30-entry tables.
- Supports a 1D column triangle (mode 0) and a 2D pyramid pluck (mode 1).
- Values are computed exactly with incremental quotient/remainder steppers, so no divider and no ROM is needed; it feeds the node-memory loader at simulation start.

Parameters:
- WIDTH, 18, node value width, signed fixed point 1.17.
- N_ROWS, 30, mesh rows (>=2).
- N_COLS, 30, mesh columns (>=2).
- PEAK, 18'h08000, value at profile apex (>0, < 2^(WIDTH-1)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE
- mode  in  1  0 = column triangle, 1 = pyramid; sampled when start is accepted
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the current value
- out_data  out  WIDTH  node value
- out_row  out  $clog2(N_ROWS)  row index of out_data
- out_col  out  $clog2(N_COLS)  column index of out_data
- out_last  out  1  high with the final node (N_ROWS-1, N_COLS-1)
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after the last handshake
- checksum  out  32  running sum of emitted out_data (see Optional Feature)

Behaviour:
- Profile definition:
  - For axis length N, define H = (N-1)/2 (floor) and k(i) = min(i, N-1-i).
  - p(i) = floor(k(i) * PEAK / H). For N=30 this gives 0, 0x00924, 0x01249, ... 0x08000 at i=14 and 15, then a mirror down to 0.
- Steppers:
  - Elaboration constants: Q = PEAK / H and R = PEAK % H.
  - Each stepper holds a value and an error term err in [0, H).
  - inc: value += Q; err += R; if err >= H then err -= H and value += 1.
  - dec: value -= Q; err -= R; if err < 0 then err += H and value -= 1.
  - clr: value = 0; err = 0.
  - Moving from i to i+1: inc if i+1 <= H; dec if i+1 > N-1-H; otherwise hold.
- out_data:
  - Mode 0: col_value.
  - Mode 1: min(row_value, col_value).
  - Depends on registered state only; no combinational path from any input.
- FSM:
  - IDLE: outputs are 0. On start, clear both steppers, set row = col = 0, latch mode, go to EMIT. out_valid rises the next cycle (latency 1).
  - EMIT: out_valid = 1; busy = 1.
    - When out_valid & out_ready: advance col. At col = N_COLS-1, set col = 0, clr the column stepper, and advance row and the row stepper.
    - While out_ready = 0, out_data, out_row, out_col and out_last are held stable.
    - A handshake with out_last goes to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. start in DONE is ignored.
- start during EMIT or DONE is ignored; the mode change does not take effect.
- Reset: rst_n = 0 at any clock edge, including mid-frame, forces IDLE. All outputs are 0, steppers and indices are 0, and checksum is 0.
- Arithmetic:
  - Stepper value is WIDTH+1 bits internally and never goes negative for valid parameters.
  - err is $clog2(H)+1 bits, signed.
  - checksum wraps modulo 2^32.

Optional Feature:
- Macro: INIT_CHECKSUM_EN.
- Defined: checksum is cleared when start is accepted and adds sign-extended out_data on every handshake. It holds its value in IDLE until the next start.
- Undefined: checksum is tied to 0 and no adder is synthesised.

Decomposition:
- Shared package drum_init_pkg holds:
  - the mode enum (MODE_TRI_1D = 0, MODE_PYRAMID = 1);
  - the FSM state typedef (IDLE, EMIT, DONE);
  - the default WIDTH/PEAK constants shared with the node-update modules.
- Sub-module profile_stepper:
  - parameters WIDTH, N, PEAK;
  - inputs inc, dec, clr;
  - output value;
  - instantiated twice, once for rows and once for columns.

Test Plan:
- Mode 0, N=30, out_ready = 1:
  - row 0 col 1 -> 0x00924; col 3 -> 0x01B6D; cols 14 and 15 -> 0x08000; col 29 -> 0x00000.
  - row 17 is identical to row 0.
  - 900 beats total; out_last on the 900th beat; done the following cycle.
- Mode 1, N=30:
  - row 0 is all zero.
  - (14,3) -> 0x01B6D; (7,20) -> 0x04000; (14,15) -> 0x08000.
- Backpressure: toggle out_ready with a random pattern including 5-cycle stalls. Data and indices must be stable while stalled, with no dropped or duplicated beats; the sequence must match the ready = 1 run.
- N_ROWS = N_COLS = 31, PEAK = 0x08000 (H = 15): col 1 -> 0x00888; col 15 -> 0x08000 only; col 16 -> 0x07777; col 30 -> 0.
- Assert rst_n = 0 at beat 400, then deassert and start mode 0: all outputs go to 0 the next cycle, and the new frame restarts at (0,0) with value 0. A start pulse mid-EMIT has no effect.
- With INIT_CHECKSUM_EN, mode 0, N=30: checksum = 0x00E0FE98 after done. Without the macro, checksum stays 0.
